// File: rtl/ifetch_rv32i.sv
// RV32I instruction fetch: drives the synchronous ROM and hands instructions to decode over valid/ready.
// Optional accepted-fetch counter is enabled with `define IFETCH_PERF_EN.
module ifetch_rv32i #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_instr,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic {StBoot, StRun} state_e;

  state_e      state;
  logic [31:0] rsp_pc;
  logic        rsp_fault;
  logic        accept;
  logic [31:0] next_pc;

  assign accept = (state == StRun) & instr_ready;

  // Stalls replay the same address so the ROM keeps presenting the held word.
  always_comb begin
    next_pc = rsp_pc;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (state == StBoot) begin
      next_pc = RESET_PC;
    end else if (accept) begin
      next_pc = rsp_pc + 32'd4;
    end
  end

  assign rom_addr = {next_pc[31:2], 2'b00};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= StBoot;
      rsp_pc    <= RESET_PC;
      rsp_fault <= 1'b0;
    end else begin
      state  <= StRun;
      rsp_pc <= next_pc;
      if (redirect_valid) begin
        rsp_fault <= |redirect_pc[1:0];
      end else if (accept) begin
        rsp_fault <= 1'b0;
      end
    end
  end

  assign instr       = rom_instr;
  assign pc_out      = rsp_pc;
  assign instr_valid = (state == StRun);
  assign fetch_fault = rsp_fault;

`ifdef IFETCH_PERF_EN
  logic [31:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 32'h0;
    end else if (accept) begin
      count <= count + 32'd1;
    end
  end

  assign fetch_count = count;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_rv32i.sv
// Self-checking bench for ifetch_rv32i: directed test-plan scenarios plus randomized
// ready/redirect traffic against a fetch-stream reference model and a behavioural ROM.
module tb_ifetch_rv32i;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  ifetch_rv32i #(
    .RESET_PC(ResetPc)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_instr     (rom_instr),
    .instr         (instr),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .fetch_fault   (fetch_fault),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_count   (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural 32-word synchronous ROM, decoding only word-address bits [6:2].
  logic [31:0] mem [32];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rom_instr <= Nop;
    else       rom_instr <= mem[rom_addr[6:2]];
  end

  int n_cmp;
  int n_bad;

  // Reference model: what decode should currently see.
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_count;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = ResetPc;
    m_fault = 1'b0;
    m_count = 32'h0;
  endtask

  task automatic check_outputs();
    check32("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    check32("pc_out", pc_out, m_pc);
    check32("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    check32("fetch_count", fetch_count, m_count);
    if (m_valid) check32("instr", instr, mem[m_pc[6:2]]);
  endtask

  // One clock cycle. Called #1 after a rising edge; leaves time #1 after the next one.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic        acc;
    logic [31:0] target;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    acc = m_valid && rdy;
    if (rv)            target = rpc;
    else if (!m_valid) target = ResetPc;
    else if (acc)      target = m_pc + 32'd4;
    else               target = m_pc;
    #2;
    check32("rom_addr", rom_addr, target & 32'hFFFF_FFFC);
    @(posedge clock);
    #1;
    if (rv)       m_fault = (rpc[1:0] != 2'b00);
    else if (acc) m_fault = 1'b0;
`ifdef IFETCH_PERF_EN
    if (acc) m_count = m_count + 32'd1;
`endif
    m_pc    = target;
    m_valid = 1'b1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    check_outputs();
    check32("instr_reset_nop", instr, Nop);
    reset = 1'b0;
    #1;
    check32("cycle0_valid", {31'b0, instr_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] base;
    logic [31:0] rpc;
    logic        rdy;
    logic        rv;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h0010_0293;
    mem[1] = 32'h0000_0333;
    mem[2] = 32'h00B0_0393;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    reset = 1'b1;
    #12;
    do_reset();

    // Boot and sequential fetch.
    cyc(1'b1, 1'b0, 32'h0);
    check32("seq_pc0", pc_out, 32'h0);
    check32("seq_i0", instr, 32'h0010_0293);
    cyc(1'b1, 1'b0, 32'h0);
    check32("seq_pc4", pc_out, 32'h4);
    check32("seq_i4", instr, 32'h0000_0333);

    // Back-pressure for three cycles while pc_out = 4.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      check32("stall_pc", pc_out, 32'h4);
      check32("stall_instr", instr, 32'h0000_0333);
    end
    cyc(1'b1, 1'b0, 32'h0);
    check32("resume_pc8", pc_out, 32'h8);
    check32("seq_i8", instr, 32'h00B0_0393);

    // Advance to 0x18 then redirect with accept.
    while (m_pc != 32'h18) cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h10);
    check32("redir_pc", pc_out, 32'h10);
    check32("redir_instr", instr, mem[4]);
    check32("redir_valid", {31'b0, instr_valid}, 32'h1);

    // Redirect while stalled: the held word at 0x10 is dropped, not counted.
    base = fetch_count;
    cyc(1'b0, 1'b1, 32'h20);
    check32("stall_redir_pc", pc_out, 32'h20);
    check32("stall_redir_cnt", fetch_count, base);

    // Misaligned redirect.
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h16;
    #1;
    check32("mis_rom_addr", rom_addr, 32'h14);
    #1;
    cyc(1'b1, 1'b1, 32'h16);
    check32("mis_pc", pc_out, 32'h16);
    check32("mis_fault", {31'b0, fetch_fault}, 32'h1);
    cyc(1'b1, 1'b0, 32'h0);
    check32("mis_next_pc", pc_out, 32'h1A);
    check32("mis_next_fault", {31'b0, fetch_fault}, 32'h0);

    // PC wrap.
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
    check32("wrap_top", pc_out, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    check32("wrap_zero", pc_out, 32'h0);

    // Asynchronous reset mid-stream.
    cyc(1'b1, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check32("async_valid", {31'b0, instr_valid}, 32'h0);
    check32("async_pc", pc_out, ResetPc);
    check32("async_cnt", fetch_count, 32'h0);
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;
    #1;
    check32("rst_cycle0_valid", {31'b0, instr_valid}, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    check32("refetch_pc", pc_out, ResetPc);

    // 10 accepts interleaved with 4 stalls after a fresh reset.
    do_reset();
    cyc(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 14; i++) cyc((i % 3) != 1 || i > 10, 1'b0, 32'h0);
`ifdef IFETCH_PERF_EN
    check32("perf_count", fetch_count, 32'd10);
`else
    check32("perf_count", fetch_count, 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 7) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0 | {28'h0, rpc[3:0]};
      cyc(rdy, rv, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_rv32i.md
# ifetch_rv32i

Instruction fetch unit for the single-cycle RV32I datapath. It drives the byte address into the 32-word synchronous instruction ROM, which returns the addressed instruction one clock later. It then presents that instruction, with its PC, to decode over a valid/ready handshake. It handles sequential PC advance, decode back-pressure and taken-branch/jump redirects with zero bubbles in steady state.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- rom_addr  output  32  byte address to the instruction ROM, combinational; rom_addr[1:0] is always 2'b00.
- rom_instr  input  32  ROM data, registered inside the ROM: the word for the rom_addr of cycle n appears in cycle n+1. Reads NOP 32'h0000_0013 while reset is high.
- instr  output  32  instruction to decode, equal to rom_instr.
- pc_out  output  32  byte PC of instr.
- instr_valid  output  1  instr/pc_out hold a live fetch.
- instr_ready  input  1  decode accepts this cycle.
- fetch_fault  output  1  the presented fetch came from a misaligned redirect; qualified by instr_valid.
- redirect_valid  input  1  a taken branch/jump; has priority over everything else.
- redirect_pc  input  32  redirect target (byte address).
- fetch_count  output  32  count of accepted fetches (see Configuration).

## Operation
- State registers:
  - rsp_valid: 0 = BOOT, 1 = RUN.
  - rsp_pc: 32-bit full address of the word currently returned by the ROM.
  - rsp_fault: 1-bit.
- accept = instr_valid & instr_ready.
- Next-address select (combinational, priority order). Let next_pc be:
  1. redirect_valid: redirect_pc.
  2. rsp_valid = 0 (BOOT): RESET_PC.
  3. accept: rsp_pc + 4, mod 2^32, so 32'hFFFF_FFFC wraps to 0.
  4. Otherwise (stall): rsp_pc. The same address is replayed, so the ROM holds its output.
- rom_addr = {next_pc[31:2], 2'b00}.
- Every clock edge out of reset:
  - rsp_pc <= next_pc.
  - rsp_valid <= 1, i.e. BOOT→RUN after one cycle.
  - rsp_fault <= (redirect_valid & |redirect_pc[1:0]) when a redirect occurs; otherwise rsp_fault holds under stall and clears on accept.
- Outputs:
  - instr_valid = rsp_valid.
  - pc_out = rsp_pc.
  - fetch_fault = rsp_fault.
- Redirect in a cycle where accept = 1: the current instruction counts as consumed.
- Redirect while stalled: the current instruction is discarded and never accepted.
- The only states are BOOT and RUN. There is no return to BOOT except through reset.

## Timing
- Reset values:
  - rsp_valid = 0 and rsp_pc = RESET_PC, so instr_valid = 0 and pc_out = RESET_PC.
  - rsp_fault = 0, so fetch_fault = 0.
  - fetch_count = 0.
  - instr follows the ROM and reads NOP.
- Cycle 0 after reset deasserts: rom_addr = RESET_PC, instr_valid = 0.
- Cycle 1: instr_valid = 1, pc_out = RESET_PC, instr = the word at RESET_PC.
- Steady state with instr_ready held high: one instruction per cycle, PC +4 per cycle, no bubbles.
- Stall: instr/pc_out stay stable for as long as instr_ready = 0. Throughput resumes in the same cycle instr_ready rises.
- Redirect latency: redirect asserted in cycle n ⇒ pc_out = redirect_pc and instr = the word at it in cycle n+1.
- Reset asserted mid-stream: all outputs return to reset values immediately (asynchronously). The fetch restarts from RESET_PC.
- Address aliasing: the ROM decodes only rom_addr[6:2], so PCs ≥ 0x80 alias. The unit does not detect this; pc_out still carries the full 32-bit PC.

## Configuration
- IFETCH_PERF_EN defined:
  - fetch_count increments by 1 on every cycle with accept = 1.
  - It wraps from 32'hFFFF_FFFF to 0.
  - Reset clears it.
- IFETCH_PERF_EN undefined: fetch_count is tied to 32'h0, and no counter flops are synthesised.

## Test plan
- Reset release, RESET_PC = 0, ROM preloaded 00100293, 00000333, 00B00393, instr_ready = 1:
  - Cycle 0: instr_valid = 0.
  - Cycles 1–3: pc_out = 0, 4, 8 with instr = 00100293, 00000333, 00B00393.
- Back-pressure: drop instr_ready for 3 cycles while pc_out = 4. Required:
  - pc_out = 4 and instr = 00000333 held throughout.
  - rom_addr = 4 throughout.
  - pc_out = 8 the cycle after instr_ready returns.
- Redirect: with redirect_valid = 1, redirect_pc = 0x10 while pc_out = 0x18. Required: next cycle pc_out = 0x10, instr = the word at 0x10, instr_valid = 1. Repeat while stalled and check the held instruction is dropped.
- Misaligned redirect to 0x0000_0016. Required:
  - rom_addr = 0x14.
  - Next cycle pc_out = 0x16 with fetch_fault = 1.
  - After accept, pc_out = 0x1A with fetch_fault = 0.
- Wrap and mid-run reset:
  - Redirect to 0xFFFF_FFFC, then accept. Required: pc_out = 0.
  - Assert reset mid-stream. Required: instr_valid = 0 immediately, then refetch from RESET_PC.
- With IFETCH_PERF_EN defined: 10 accepts interleaved with 4 stall cycles ⇒ fetch_count = 10. Without the macro, fetch_count = 0 throughout.
